// File: rtl/disp_write_sched.sv
// Display register write scheduler.
// Two requesters (processor, game logic) post register writes. Writes are
// queued in a small in-order FIFO and released to the display register port
// only while the display is in vertical blank. Writes to addresses 6 and up
// are acknowledged but silently dropped.
module disp_write_sched #(
  parameter int DEPTH = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       r0_valid,
  input  logic [3:0] r0_addr,
  input  logic [7:0] r0_data,
  output logic       r0_ready,
  input  logic       r1_valid,
  input  logic [3:0] r1_addr,
  input  logic [7:0] r1_data,
  output logic       r1_ready,
  input  logic       vblank,
  output logic       dsp_chipselect,
  output logic       dsp_write,
  output logic [3:0] dsp_address,
  output logic [7:0] dsp_writedata,
  output logic [4:0] pending,
  output logic       frame_tick,
  output logic       overflow_err
);

  localparam int PW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, WAIT_BLANK, DRAIN} state_t;

  state_t        state;
  logic [11:0]   mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [4:0]    count;
  logic [4:0]    count_next;
  logic          last_r1;
  logic          vblank_d;

  logic          full;
  logic          sel_r1;
  logic          accept;
  logic [3:0]    acc_addr;
  logic [7:0]    acc_data;
  logic          push;
  logic          pop;
  logic [11:0]   head_p0;

  // Full is judged on registered occupancy, so a same-cycle pop never
  // frees a slot for the requesters.
  assign full = (count == 5'(DEPTH));

  // Round-robin: with both requesting, the one not granted last wins.
  assign sel_r1   = r1_valid & (~r0_valid | ~last_r1);
  assign r0_ready = r0_valid & ~sel_r1 & ~full;
  assign r1_ready = sel_r1 & ~full;
  assign accept   = (r0_valid | r1_valid) & ~full;
  assign acc_addr = sel_r1 ? r1_addr : r0_addr;
  assign acc_data = sel_r1 ? r1_data : r0_data;

  // Addresses 6..15 complete the handshake but never enter the queue.
  assign push       = accept & (acc_addr < 4'd6);
  assign pop        = (state == DRAIN) & vblank & (count != 5'd0);
  assign count_next = count + {4'd0, push} - {4'd0, pop};
  assign head_p0    = mem[rd_ptr];

  assign pending    = count;
  assign frame_tick = vblank & ~vblank_d;

  // Queue bookkeeping, arbitration pointer, sticky overflow and blank edge history.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count        <= 5'd0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      last_r1      <= 1'b1;
      overflow_err <= 1'b0;
      vblank_d     <= 1'b1;
    end else begin
      count <= count_next;
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      if (accept) last_r1 <= sel_r1;
      if ((r0_valid | r1_valid) & full) overflow_err <= 1'b1;
      vblank_d <= vblank;
    end
  end

  // Queue storage; contents are don't-care while the slot is empty.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {acc_addr, acc_data};
  end

  // Blank-gated drain sequencer with registered display-port outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      dsp_chipselect <= 1'b0;
      dsp_write      <= 1'b0;
      dsp_address    <= 4'd0;
      dsp_writedata  <= 8'd0;
    end else begin
      // stage p0 -> output: popped head lands on the display port next cycle
      dsp_chipselect <= pop;
      dsp_write      <= pop;
      if (pop) begin
        dsp_address   <= head_p0[11:8];
        dsp_writedata <= head_p0[7:0];
      end
      case (state)
        IDLE: begin
          if (count != 5'd0) state <= vblank ? DRAIN : WAIT_BLANK;
        end
        WAIT_BLANK: begin
          if (vblank) state <= DRAIN;
        end
        DRAIN: begin
          if (!vblank)                 state <= (count != 5'd0) ? WAIT_BLANK : IDLE;
          else if (count_next == 5'd0) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_disp_write_sched.sv
// Bench for disp_write_sched: directed scenarios with literal expectations
// plus a long randomized run compared every cycle against a queue model.
module tb_disp_write_sched;

  localparam int DEPTH = 8;

  logic       clk = 1'b0;
  logic       reset;
  logic       r0_valid, r1_valid;
  logic [3:0] r0_addr, r1_addr;
  logic [7:0] r0_data, r1_data;
  logic       r0_ready, r1_ready;
  logic       vblank;
  logic       dsp_chipselect, dsp_write;
  logic [3:0] dsp_address;
  logic [7:0] dsp_writedata;
  logic [4:0] pending;
  logic       frame_tick, overflow_err;

  int errors = 0;
  int checks = 0;
  int wr_cnt = 0;

  disp_write_sched #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .r0_valid(r0_valid), .r0_addr(r0_addr), .r0_data(r0_data), .r0_ready(r0_ready),
    .r1_valid(r1_valid), .r1_addr(r1_addr), .r1_data(r1_data), .r1_ready(r1_ready),
    .vblank(vblank),
    .dsp_chipselect(dsp_chipselect), .dsp_write(dsp_write),
    .dsp_address(dsp_address), .dsp_writedata(dsp_writedata),
    .pending(pending), .frame_tick(frame_tick), .overflow_err(overflow_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Queue of {addr,data}; a pop happens in a cycle when blank was high in this
  // and the previous cycle with data waiting in both; its write shows one cycle later.
  logic [11:0] mq[$];
  bit          m_last_r1 = 1'b1;
  bit          m_prev_vb = 1'b0;
  int          m_prev_occ = 0;
  bit          m_w = 1'b0;
  logic [3:0]  m_addr = 4'd0;
  logic [7:0]  m_data = 8'd0;
  bit          m_ovf = 1'b0;
  bit          m_vbd = 1'b1;
  int          mocc;
  bit          mfull, msel1, macc, mpop;
  logic [3:0]  ma;
  logic [7:0]  md;

  function automatic bit exp_sel_r1();
    return r1_valid && (!r0_valid || !m_last_r1);
  endfunction

  initial begin
    forever begin
      @(posedge clk or posedge reset);
      if (reset) begin
        mq.delete();
        m_last_r1 = 1'b1; m_prev_vb = 1'b0; m_prev_occ = 0;
        m_w = 1'b0; m_addr = 4'd0; m_data = 8'd0; m_ovf = 1'b0; m_vbd = 1'b1;
      end else begin
        mocc  = mq.size();
        mfull = (mocc == DEPTH);
        msel1 = exp_sel_r1();
        macc  = (r0_valid || r1_valid) && !mfull;
        ma    = msel1 ? r1_addr : r0_addr;
        md    = msel1 ? r1_data : r0_data;
        mpop  = vblank && m_prev_vb && (m_prev_occ > 0) && (mocc > 0);
        if (mpop) begin
          m_w = 1'b1; m_addr = mq[0][11:8]; m_data = mq[0][7:0];
          void'(mq.pop_front());
        end else begin
          m_w = 1'b0;
        end
        if (macc) begin
          if (ma < 4'd6) mq.push_back({ma, md});
          m_last_r1 = msel1;
        end
        if ((r0_valid || r1_valid) && mfull) m_ovf = 1'b1;
        m_prev_vb = vblank; m_prev_occ = mocc; m_vbd = vblank;
      end
    end
  end

  // Every-cycle comparison against the model.
  initial begin
    forever begin
      @(negedge clk);
      check("r0_ready", int'(r0_ready), int'(r0_valid && !exp_sel_r1() && mq.size() != DEPTH));
      check("r1_ready", int'(r1_ready), int'(exp_sel_r1() && mq.size() != DEPTH));
      check("pending", int'(pending), mq.size());
      check("dsp_write", int'(dsp_write), int'(m_w));
      check("dsp_chipselect", int'(dsp_chipselect), int'(m_w));
      check("dsp_address", int'(dsp_address), int'(m_addr));
      check("dsp_writedata", int'(dsp_writedata), int'(m_data));
      check("frame_tick", int'(frame_tick), int'(vblank && !m_vbd));
      check("overflow_err", int'(overflow_err), int'(m_ovf));
      if (dsp_write) wr_cnt++;
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; r0_valid = 1'b0; r1_valid = 1'b0;
    tick(); tick();
    reset = 1'b0;
  endtask

  logic [3:0] ea [4];
  logic [7:0] ed [4];
  int  n0, n1, nw, first, w0;
  bit  g0, g1, h0, h1, done;

  initial begin
    reset = 1'b1; vblank = 1'b1;
    r0_valid = 1'b0; r0_addr = 4'd0; r0_data = 8'd0;
    r1_valid = 1'b0; r1_addr = 4'd0; r1_data = 8'd0;
    tick(); tick();
    @(negedge clk);
    check("rst_pending", int'(pending), 0);
    check("rst_write", int'(dsp_write), 0);
    check("rst_ovf", int'(overflow_err), 0);
    check("rst_tick", int'(frame_tick), 0);
    tick(); reset = 1'b0;
    tick(); tick();
    check("rst_no_tick", int'(frame_tick), 0);

    // Case 1: single write with blank high, visible exactly three cycles later
    r0_valid = 1'b1; r0_addr = 4'd0; r0_data = 8'h2A;
    @(negedge clk);
    check("c1_ready", int'(r0_ready), 1);
    for (int k = 1; k <= 4; k++) begin
      tick();
      if (k == 1) r0_valid = 1'b0;
      @(negedge clk);
      check("c1_write", int'(dsp_write), int'(k == 3));
      if (k == 3) begin
        check("c1_addr", int'(dsp_address), 0);
        check("c1_data", int'(dsp_writedata), 8'h2A);
      end
    end

    // Case 2: both requesters contend outside blank, then drain in order
    vblank = 1'b0; do_reset();
    r0_valid = 1'b1; r0_addr = 4'd1; r0_data = 8'hA0;
    r1_valid = 1'b1; r1_addr = 4'd3; r1_data = 8'hB0;
    n0 = 0; n1 = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("c2_r0_grant", int'(r0_ready), int'(k % 2 == 0));
      check("c2_r1_grant", int'(r1_ready), int'(k % 2 == 1));
      g0 = r0_ready; g1 = r1_ready;
      tick();
      if (g0) begin n0++; r0_data = 8'(8'hA0 + n0); end
      if (g1) begin n1++; r1_data = 8'(8'hB0 + n1); end
    end
    r0_valid = 1'b0; r1_valid = 1'b0;
    @(negedge clk);
    check("c2_pending", int'(pending), 4);
    repeat (3) tick();
    check("c2_hold", int'(pending), 4);
    ea[0] = 4'd1; ea[1] = 4'd3; ea[2] = 4'd1; ea[3] = 4'd3;
    ed[0] = 8'hA0; ed[1] = 8'hB0; ed[2] = 8'hA1; ed[3] = 8'hB1;
    vblank = 1'b1; nw = 0; first = -1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (dsp_write) begin
        if (nw == 0) first = c;
        check("c2_consecutive", c, first + nw);
        if (nw < 4) begin
          check("c2_order_addr", int'(dsp_address), int'(ea[nw]));
          check("c2_order_data", int'(dsp_writedata), int'(ed[nw]));
        end
        nw++;
      end
      tick();
    end
    check("c2_nwrites", nw, 4);

    // Case 3: nine offers into an eight-deep queue
    vblank = 1'b0; do_reset();
    r0_valid = 1'b1; r0_addr = 4'd2; r0_data = 8'd0;
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      check("c3_ready", int'(r0_ready), int'(k < 8));
      if (k == 7) check("c3_ovf_before", int'(overflow_err), 0);
      g0 = r0_ready;
      tick();
      if (g0) r0_data = r0_data + 8'd1;
    end
    r0_valid = 1'b0;
    @(negedge clk);
    check("c3_pending", int'(pending), 8);
    check("c3_ovf", int'(overflow_err), 1);
    tick();
    vblank = 1'b1; done = 1'b0;
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge clk);
      if (pending == 5'd0) done = 1'b1;
    end
    check("c3_drained", int'(done), 1);
    tick(); tick();
    check("c3_ovf_sticky", int'(overflow_err), 1);

    // Case 4: blank ends after three writes, remainder waits for the next blank
    vblank = 1'b0; do_reset();
    r1_valid = 1'b1; r1_addr = 4'd4;
    for (int i = 0; i < 6; i++) begin
      r1_data = 8'(8'h40 + i);
      tick();
    end
    r1_valid = 1'b0;
    @(negedge clk);
    check("c4_pending6", int'(pending), 6);
    tick();
    w0 = wr_cnt;
    vblank = 1'b1;
    repeat (4) tick();
    vblank = 1'b0;
    tick();
    check("c4_writes3", wr_cnt - w0, 3);
    @(negedge clk);
    check("c4_pending3", int'(pending), 3);
    repeat (4) tick();
    check("c4_wait_writes", wr_cnt - w0, 3);
    check("c4_wait_pending", int'(pending), 3);
    vblank = 1'b1;
    repeat (8) tick();
    check("c4_writes6", wr_cnt - w0, 6);
    check("c4_empty", int'(pending), 0);

    // Case 5: filtered address completes handshake without queuing
    r1_valid = 1'b1; r1_addr = 4'd7; r1_data = 8'h55;
    @(negedge clk);
    check("c5_ready", int'(r1_ready), 1);
    tick();
    r1_valid = 1'b0; w0 = wr_cnt;
    repeat (5) begin
      @(negedge clk);
      check("c5_pending", int'(pending), 0);
    end
    tick();
    check("c5_nowrite", wr_cnt - w0, 0);

    // Case 6: reset during drain, then frame_tick only on a fresh rise
    vblank = 1'b0; do_reset();
    r0_valid = 1'b1; r0_addr = 4'd5;
    for (int i = 0; i < 4; i++) begin
      r0_data = 8'(8'h60 + i);
      tick();
    end
    r0_valid = 1'b0;
    vblank = 1'b1;
    tick(); tick();
    check("c6_writing", int'(dsp_write), 1);
    reset = 1'b1;
    #1;
    check("c6_rst_write", int'(dsp_write), 0);
    check("c6_rst_pending", int'(pending), 0);
    tick();
    reset = 1'b0;
    repeat (4) begin
      @(negedge clk);
      check("c6_no_tick", int'(frame_tick), 0);
      tick();
    end
    vblank = 1'b0;
    tick(); tick();
    vblank = 1'b1;
    @(negedge clk);
    check("c6_tick", int'(frame_tick), 1);
    tick();
    @(negedge clk);
    check("c6_tick_pulse", int'(frame_tick), 0);
    tick();

    // Randomized traffic; a refused request is held unchanged until accepted
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      h0 = r0_valid && !r0_ready;
      h1 = r1_valid && !r1_ready;
      tick();
      if (!h0) begin
        r0_valid = 1'($urandom_range(0, 1));
        r0_addr  = 4'($urandom_range(0, 15));
        r0_data  = 8'($urandom);
      end
      if (!h1) begin
        r1_valid = 1'($urandom_range(0, 1));
        r1_addr  = 4'($urandom_range(0, 15));
        r1_data  = 8'($urandom);
      end
      if ($urandom_range(0, 19) == 0) vblank = ~vblank;
      if (c == 1500) begin
        reset = 1'b1; #2; reset = 1'b0;
      end
    end
    r0_valid = 1'b0; r1_valid = 1'b0;
    tick(); tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
